// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares the 512-byte memory between CPU and DMA ports, one access
//            per clock, with bounded DMA burst lock and 1-cycle read return.
// Options  : MEM_ARB_ROUND_ROBIN_EN - alternate tie-break instead of CPU-first.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int MEM_DEPTH = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_last,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [7:0]  dma_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [8:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        oor_err,
    output logic [1:0]  arb_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_COOL  = 2'd2
    } state_t;

    localparam logic [3:0]  C_MAX_BURST = 4'(MAX_BURST);
    localparam logic [16:0] C_MEM_DEPTH = 17'(MEM_DEPTH);
    localparam logic        C_BURST_EN  = (MAX_BURST > 1);

    state_t      state_q, state_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic        last_dma_q, last_dma_d;
    logic        oor_err_q, oor_err_d;
    logic        cpu_rvalid_q, cpu_rvalid_d;
    logic        dma_rvalid_q, dma_rvalid_d;
    logic        rd_oor_q, rd_oor_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  dma_rdata_q, dma_rdata_d;

    logic        w_cpu_gnt;
    logic        w_dma_gnt;
    logic        w_any_gnt;
    logic        w_cpu_wins_tie;
    logic        w_sel_we;
    logic [15:0] w_sel_addr;
    logic [7:0]  w_sel_wdata;
    logic        w_sel_in_range;
    logic [7:0]  w_rd_value;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign w_cpu_wins_tie = last_dma_q;
`else
    assign w_cpu_wins_tie = 1'b1;
`endif

    // Grants are gated by reset so every output reads zero while it is held.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req && dma_req) begin
                        w_cpu_gnt = w_cpu_wins_tie;
                        w_dma_gnt = !w_cpu_wins_tie;
                    end else begin
                        w_cpu_gnt = cpu_req;
                        w_dma_gnt = dma_req;
                    end
                end
                ST_BURST: begin
                    w_dma_gnt = dma_req;
                    w_cpu_gnt = cpu_req && !dma_req;
                end
                ST_COOL: w_cpu_gnt = cpu_req;
                default: ;
            endcase
        end
    end

    assign w_any_gnt      = w_cpu_gnt | w_dma_gnt;
    assign w_sel_we       = w_cpu_gnt ? cpu_we    : dma_we;
    assign w_sel_addr     = w_cpu_gnt ? cpu_addr  : dma_addr;
    assign w_sel_wdata    = w_cpu_gnt ? cpu_wdata : dma_wdata;
    assign w_sel_in_range = ({1'b0, w_sel_addr} < C_MEM_DEPTH);

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        last_dma_d   = w_dma_gnt ? 1'b1 : (w_cpu_gnt ? 1'b0 : last_dma_q);
        oor_err_d    = oor_err_q | (w_any_gnt & !w_sel_in_range);
        cpu_rvalid_d = w_cpu_gnt & !cpu_we;
        dma_rvalid_d = w_dma_gnt & !dma_we;
        rd_oor_d     = !w_sel_in_range;
        cpu_rdata_d  = cpu_rvalid_q ? w_rd_value : cpu_rdata_q;
        dma_rdata_d  = dma_rvalid_q ? w_rd_value : dma_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_dma_gnt && !dma_last && C_BURST_EN) begin
                    state_d    = ST_BURST;
                    beat_cnt_d = 4'd1;
                end
            end
            ST_BURST: begin
                // A full burst always pays its cool-down, even on a last beat.
                if (!dma_req) begin
                    state_d    = ST_IDLE;
                    beat_cnt_d = 4'd0;
                end else if (beat_cnt_q + 4'd1 == C_MAX_BURST) begin
                    state_d    = ST_COOL;
                    beat_cnt_d = 4'd0;
                end else if (dma_last) begin
                    state_d    = ST_IDLE;
                    beat_cnt_d = 4'd0;
                end else begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
            ST_COOL: state_d = ST_IDLE;
            default: begin
                state_d    = ST_IDLE;
                beat_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= 4'd0;
            last_dma_q   <= 1'b1;
            oor_err_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            rd_oor_q     <= 1'b0;
            cpu_rdata_q  <= 8'h00;
            dma_rdata_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            last_dma_q   <= last_dma_d;
            oor_err_q    <= oor_err_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            rd_oor_q     <= rd_oor_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    // The RAM output register supplies in-range data in the return cycle.
    assign w_rd_value = rd_oor_q ? 8'hFF : mem_rdata;

    assign cpu_gnt    = w_cpu_gnt;
    assign dma_gnt    = w_dma_gnt;
    assign mem_en     = w_any_gnt & w_sel_in_range;
    assign mem_we     = mem_en & w_sel_we;
    assign mem_addr   = mem_en ? w_sel_addr[8:0] : 9'd0;
    assign mem_wdata  = (mem_en & w_sel_we) ? w_sel_wdata : 8'h00;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;
    assign cpu_rdata  = cpu_rvalid_q ? w_rd_value : cpu_rdata_q;
    assign dma_rdata  = dma_rvalid_q ? w_rd_value : dma_rdata_q;
    assign oor_err    = oor_err_q;
    assign arb_state  = state_q;

endmodule
`default_nettype wire
